// File: rtl/sd_speicher.sv
// -----------------------------------------------------------------------------
// sd_speicher
//
// Copies a block of RAM words to an SD card, one word per write. The first
// word written is a header that holds the word count. The data words follow
// at the next SD addresses.
//
// Order of writes for a dump of N words:
//   SD_BASIS          <- N (zero-extended to 32 bits)
//   SD_BASIS + 1 + k  <- RAM[(RAM_BASIS + k) mod 2^16],  k = 0 .. N-1
//   SD_BASIS + N + 1  <- sum of all data words mod 2^32
//                        (this write exists only with SD_SPEICHER_PRUEFSUMME_EN)
//
// Optional feature macro: SD_SPEICHER_PRUEFSUMME_EN
//   If this macro is defined, a checksum word is appended after the data.
//   If it is undefined, no checksum logic is built and exactly N+1 writes occur.
//
// Parameters:
//   SD_BASIS     SD word address of the header word.
//   RAM_BASIS    First RAM word address that is dumped.
//
// Ports:
//   Clock         Single clock. All state changes happen on its rising edge.
//   Reset         Asynchronous reset, active high.
//   Start         One-cycle request to begin a dump. Only accepted when idle.
//   Anzahl        Number of data words. Sampled when Start is accepted.
//   RAMAdresse    RAM read address.
//   RAMDatenRaus  RAM read data. Valid one cycle after RAMAdresse.
//   SDAdresse     SD word address of the current write.
//   SDDaten       Word to be written.
//   SDSchreiben   One-cycle write request to the SD writer.
//   SDBusy        The SD writer is initialising or writing.
//   Aktiv         A dump is in progress.
//   Fertig        One-cycle pulse when a dump completes.
//   Zustand       Current state encoding, shown on the LEDs.
//
// Write handshake (the only handshake in this block):
//   A write is issued only after SDBusy has been seen low. SDSchreiben is then
//   high for exactly one cycle. SDAdresse and SDDaten change only when a new
//   write is issued, so they stay stable while the writer is busy. In the
//   cycle right after the pulse the writer may not yet have raised SDBusy.
//   For that reason SDWARTEN ignores SDBusy in that cycle. After that it waits
//   for SDBusy to go low before it continues.
// -----------------------------------------------------------------------------
module sd_speicher #(
    parameter logic [31:0] SD_BASIS  = 32'd0,
    parameter logic [15:0] RAM_BASIS = 16'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Anzahl,
    output logic [15:0] RAMAdresse,
    input  logic [31:0] RAMDatenRaus,
    output logic [31:0] SDAdresse,
    output logic [31:0] SDDaten,
    output logic        SDSchreiben,
    input  logic        SDBusy,
    output logic        Aktiv,
    output logic        Fertig,
    output logic [2:0]  Zustand
);

    // State encoding. These values appear directly on the LEDs via Zustand.
    typedef enum logic [2:0] {
        LEERLAUF   = 3'd0,
        KOPF       = 3'd1,
        RAMLESEN   = 3'd2,
        RAMWARTEN  = 3'd3,
        SCHREIBEN  = 3'd4,
        SDWARTEN   = 3'd5,
        ENDE       = 3'd6
`ifdef SD_SPEICHER_PRUEFSUMME_EN
        ,
        PRUEFSUMME = 3'd7
`endif
    } zustand_t;

    zustand_t    zustand;       // current state
    logic [15:0] zaehler;       // data words still to be written
    logic [15:0] ram_zeiger;    // next RAM word to read
    logic [31:0] sd_zeiger;     // SD address of the next write
    logic [31:0] daten;         // last word read from RAM
    logic [31:0] sd_adresse;    // registered SDAdresse
    logic [31:0] sd_daten;      // registered SDDaten
    logic        sd_schreiben;  // registered SDSchreiben
    logic        fertig;        // registered Fertig
    logic        erster;        // high in the first SDWARTEN cycle after a pulse

`ifdef SD_SPEICHER_PRUEFSUMME_EN
    logic [31:0] summe;         // running sum of the data words
    logic        pruef_fertig;  // the checksum word has been issued
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand      <= LEERLAUF;
            zaehler      <= 16'd0;
            ram_zeiger   <= 16'd0;
            sd_zeiger    <= 32'd0;
            daten        <= 32'd0;
            sd_adresse   <= 32'd0;
            sd_daten     <= 32'd0;
            sd_schreiben <= 1'b0;
            fertig       <= 1'b0;
            erster       <= 1'b0;
`ifdef SD_SPEICHER_PRUEFSUMME_EN
            summe        <= 32'd0;
            pruef_fertig <= 1'b0;
`endif
        end else begin
            // Both strobes are single-cycle pulses. A state below sets them
            // again only when it actually issues a write or finishes.
            sd_schreiben <= 1'b0;
            fertig       <= 1'b0;

            case (zustand)
                LEERLAUF: begin
                    if (Start) begin
                        zaehler    <= Anzahl;
                        ram_zeiger <= RAM_BASIS;
                        sd_zeiger  <= SD_BASIS;
`ifdef SD_SPEICHER_PRUEFSUMME_EN
                        summe        <= 32'd0;
                        pruef_fertig <= 1'b0;
`endif
                        zustand    <= KOPF;
                    end
                end

                // The header carries the word count. zaehler still holds
                // the latched Anzahl here, so later changes of Anzahl
                // cannot reach the header.
                KOPF: begin
                    if (!SDBusy) begin
                        sd_schreiben <= 1'b1;
                        sd_adresse   <= sd_zeiger;
                        sd_daten     <= {16'd0, zaehler};
                        erster       <= 1'b1;
                        zustand      <= SDWARTEN;
                    end
                end

                SDWARTEN: begin
                    if (erster) begin
                        erster <= 1'b0;
                    end else if (!SDBusy) begin
                        sd_zeiger <= sd_zeiger + 32'd1;
                        if (zaehler != 16'd0) begin
                            zustand <= RAMLESEN;
                        end else begin
`ifdef SD_SPEICHER_PRUEFSUMME_EN
                            if (!pruef_fertig) begin
                                zustand <= PRUEFSUMME;
                            end else begin
                                fertig  <= 1'b1;
                                zustand <= ENDE;
                            end
`else
                            // Fertig is set on entry so that its pulse
                            // falls in the ENDE cycle.
                            fertig  <= 1'b1;
                            zustand <= ENDE;
`endif
                        end
                    end
                end

                // RAMAdresse is taken directly from ram_zeiger. It is
                // therefore valid for the whole RAMLESEN cycle, and the RAM
                // returns the data in RAMWARTEN.
                RAMLESEN: begin
                    zustand <= RAMWARTEN;
                end

                RAMWARTEN: begin
                    daten   <= RAMDatenRaus;
                    zustand <= SCHREIBEN;
                end

                SCHREIBEN: begin
                    if (!SDBusy) begin
                        sd_schreiben <= 1'b1;
                        sd_adresse   <= sd_zeiger;
                        sd_daten     <= daten;
                        ram_zeiger   <= ram_zeiger + 16'd1;
                        zaehler      <= zaehler - 16'd1;
`ifdef SD_SPEICHER_PRUEFSUMME_EN
                        summe        <= summe + daten;
`endif
                        erster       <= 1'b1;
                        zustand      <= SDWARTEN;
                    end
                end

`ifdef SD_SPEICHER_PRUEFSUMME_EN
                // After the last data word, sd_zeiger already points to
                // SD_BASIS + N + 1. That address receives the checksum.
                PRUEFSUMME: begin
                    if (!SDBusy) begin
                        sd_schreiben <= 1'b1;
                        sd_adresse   <= sd_zeiger;
                        sd_daten     <= summe;
                        pruef_fertig <= 1'b1;
                        erster       <= 1'b1;
                        zustand      <= SDWARTEN;
                    end
                end
`endif

                ENDE: begin
                    zustand <= LEERLAUF;
                end

                default: begin
                    zustand <= LEERLAUF;
                end
            endcase
        end
    end

    assign RAMAdresse  = ram_zeiger;
    assign SDAdresse   = sd_adresse;
    assign SDDaten     = sd_daten;
    assign SDSchreiben = sd_schreiben;
    assign Fertig      = fertig;
    assign Aktiv       = (zustand != LEERLAUF);
    assign Zustand     = zustand;

endmodule

// File: tb/tb_sd_speicher.sv
module tb_sd_speicher;

    // Non-default bases: the dump wraps in both the RAM and the SD address space.
    localparam logic [31:0] SDB = 32'hFFFF_FFFE;
    localparam logic [15:0] RB  = 16'hFFFF;
`ifdef SD_SPEICHER_PRUEFSUMME_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Anzahl = 16'd0;
    logic [15:0] RAMAdresse;
    logic [31:0] RAMDatenRaus;
    logic [31:0] SDAdresse;
    logic [31:0] SDDaten;
    logic        SDSchreiben;
    logic        SDBusy = 1'b0;
    logic        Aktiv;
    logic        Fertig;
    logic [2:0]  Zustand;

    sd_speicher #(
        .SD_BASIS (SDB),
        .RAM_BASIS(RB)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Anzahl      (Anzahl),
        .RAMAdresse  (RAMAdresse),
        .RAMDatenRaus(RAMDatenRaus),
        .SDAdresse   (SDAdresse),
        .SDDaten     (SDDaten),
        .SDSchreiben (SDSchreiben),
        .SDBusy      (SDBusy),
        .Aktiv       (Aktiv),
        .Fertig      (Fertig),
        .Zustand     (Zustand)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    // ---------------- synchronous RAM model ----------------
    logic [31:0] ram [0:65535];
    always @(posedge Clock) RAMDatenRaus <= ram[RAMAdresse];

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    int writes_seen = 0;
    int fertig_cnt = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    bit busy_force = 1'b0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_d = 32'd0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SD writer model and write monitor. It samples on the falling edge.
    always @(negedge Clock) begin
        if (Reset) begin
            busy_cnt = 0;
        end else begin
            if (Fertig) fertig_cnt++;
            if (SDSchreiben) begin
                check("busy_at_pulse", 64'(SDBusy), 64'd0);
                if (exp_q.size() != 0) begin
                    check("write", {SDAdresse, SDDaten}, exp_q.pop_front());
                end else begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_write: observed %0h/%0h expected none", SDAdresse, SDDaten);
                end
                writes_seen++;
                last_a   = SDAdresse;
                last_d   = SDDaten;
                busy_cnt = busy_len;
            end else if (busy_cnt != 0) begin
                check("hold", {SDAdresse, SDDaten}, {last_a, last_d});
                busy_cnt--;
            end
        end
        SDBusy = busy_force || (busy_cnt != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    task automatic start_dump(input logic [15:0] n);
        logic [31:0] sum;
        logic [15:0] ra;
        logic [31:0] a;
        sum = 32'd0;
        exp_q.push_back({SDB, 16'd0, n});
        for (int k = 0; k < int'(n); k++) begin
            ra = RB + k[15:0];
            a  = SDB + 32'd1 + k[31:0];
            exp_q.push_back({a, ram[ra]});
            sum = sum + ram[ra];
        end
        if (CS != 0) exp_q.push_back({SDB + 32'd1 + {16'd0, n}, sum});
        Anzahl = n;
        Start  = 1'b1;
        step(1);
        Start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while ((Aktiv !== 1'b0 || exp_q.size() != 0) && c < 2000) begin
            step(1);
            c++;
        end
        check(tag, 64'(c < 2000), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_zustand"}, 64'(Zustand), 64'd0);
        check({tag, "_aktiv"}, 64'(Aktiv), 64'd0);
        check({tag, "_schreiben"}, 64'(SDSchreiben), 64'd0);
        check({tag, "_fertig"}, 64'(Fertig), 64'd0);
        check({tag, "_ramadr"}, 64'(RAMAdresse), 64'd0);
        check({tag, "_sdadr"}, 64'(SDAdresse), 64'd0);
        check({tag, "_sddaten"}, 64'(SDDaten), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0;
        int f0;
        int c;

        // Reset takes effect without a clock edge.
        #2 Reset = 1'b1;
        #1 check_reset_outputs("reset");
        step(2);
        Reset = 1'b0;
        step(1);

        // Three words across the RAM wrap, writer busy 4 cycles per write.
        ram[16'hFFFF] = 32'd11;
        ram[16'h0000] = 32'd22;
        ram[16'h0001] = 32'd33;
        busy_len = 4;
        w0 = writes_seen;
        f0 = fertig_cnt;
        start_dump(16'd3);
        check("a_zustand_kopf", 64'(Zustand), 64'd1);
        check("a_aktiv", 64'(Aktiv), 64'd1);
        wait_idle("a_done");
        check("a_writes", 64'(writes_seen - w0), 64'(4 + CS));
        check("a_fertig", 64'(fertig_cnt - f0), 64'd1);
        check("a_zustand_idle", 64'(Zustand), 64'd0);

        // Zero words: header only (plus zero checksum when enabled).
        busy_len = 2;
        w0 = writes_seen;
        f0 = fertig_cnt;
        start_dump(16'd0);
        wait_idle("b_done");
        check("b_writes", 64'(writes_seen - w0), 64'(1 + CS));
        check("b_fertig", 64'(fertig_cnt - f0), 64'd1);

        // Writer busy for 100 cycles after Start: no write may be issued yet.
        busy_force = 1'b1;
        step(1);
        ram[16'hFFFF] = $urandom;
        w0 = writes_seen;
        f0 = fertig_cnt;
        start_dump(16'd1);
        step(100);
        check("c_no_write_while_busy", 64'(writes_seen - w0), 64'd0);
        check("c_waiting_in_kopf", 64'(Zustand), 64'd1);
        busy_force = 1'b0;
        wait_idle("c_done");
        check("c_writes", 64'(writes_seen - w0), 64'(2 + CS));
        check("c_fertig", 64'(fertig_cnt - f0), 64'd1);

        // Start repeated mid-dump with a different Anzahl is ignored.
        for (int i = 0; i < 4; i++) ram[RB + i[15:0]] = $urandom;
        busy_len = $urandom_range(1, 3);
        w0 = writes_seen;
        f0 = fertig_cnt;
        start_dump(16'd2);
        step(2);
        check("d_aktiv_1", 64'(Aktiv), 64'd1);
        Anzahl = 16'd5;
        Start  = 1'b1;
        step(1);
        Start  = 1'b0;
        step(4);
        check("d_aktiv_2", 64'(Aktiv), 64'd1);
        Anzahl = 16'd7;
        Start  = 1'b1;
        step(1);
        Start  = 1'b0;
        wait_idle("d_done");
        check("d_writes", 64'(writes_seen - w0), 64'(3 + CS));
        check("d_fertig", 64'(fertig_cnt - f0), 64'd1);
        step(3);
        check("d_stays_idle", 64'(Aktiv), 64'd0);

        // Reset during the second data write aborts without Fertig.
        for (int i = 0; i < 4; i++) ram[RB + i[15:0]] = $urandom;
        busy_len = 4;
        w0 = writes_seen;
        f0 = fertig_cnt;
        start_dump(16'd3);
        c = 0;
        while (writes_seen - w0 < 3 && c < 500) begin
            step(1);
            c++;
        end
        check("e_second_data_write", 64'(writes_seen - w0), 64'd3);
        Reset = 1'b1;
        #1 check_reset_outputs("e_abort");
        exp_q.delete();
        step(2);
        Reset = 1'b0;
        w0 = writes_seen;
        step(5);
        check("e_no_fertig", 64'(fertig_cnt - f0), 64'd0);
        check("e_idle_after_reset", 64'(Zustand), 64'd0);
        check("e_no_auto_restart", 64'(writes_seen - w0), 64'd0);

        // A new Start restarts from the header.
        ram[16'hFFFF] = $urandom;
        f0 = fertig_cnt;
        start_dump(16'd1);
        wait_idle("e_restart_done");
        check("e_restart_writes", 64'(writes_seen - w0), 64'(2 + CS));
        check("e_restart_fertig", 64'(fertig_cnt - f0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
